// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with registered result and flags.
// Single-cycle ops: ADD, SUB, ADDI, AND, OR, XOR, AGEN.
// Shifts (SLL/SRL/SRA) run in an iterative shifter at one bit per cycle.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         input handshake for op, a, b, imm
//   op[3:0]                   0 ADD,1 SUB,2 ADDI,3 AND,4 OR,5 XOR,6 SLL,7 SRL,8 SRA,9 AGEN
//   a, b [WIDTH-1:0]          operands; shifts use b[SHAMT_W-1:0]
//   imm [IMM_W-1:0]           immediate/offset, sign-extended
//   out_valid/out_ready       output handshake
//   result, flag_z/n/c/v, err registered result, flags, illegal-op indicator
//   busy                      FSM not idle
module alu_seq_core #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IMM_W   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [IMM_W-1:0]   imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_v,
    output logic               err,
    output logic               busy
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAddi = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSll  = 4'd6;
    localparam logic [3:0] OpSrl  = 4'd7;
    localparam logic [3:0] OpSra  = 4'd8;
    localparam logic [3:0] OpAgen = 4'd9;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

    state_e             state_q, state_d;
    shift_e             shift_q, shift_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    // result_q doubles as the shifter working register while in StShift.
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;

    logic               accept;
    logic [WIDTH-1:0]   imm_ext;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v, res_err;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;

    always_comb begin
        in_ready = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
        accept   = in_valid && in_ready;
        imm_ext  = WIDTH'($signed(imm));
        add_b    = (op == OpAdd) ? b : imm_ext;
        sum      = {1'b0, a} + {1'b0, add_b};
        diff     = {1'b0, a} - {1'b0, b};
        amt      = b[SHAMT_W-1:0];
    end

    // Single-cycle datapath result for the op on the input port.
    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (op)
            OpAdd, OpAddi, OpAgen: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[Msb] == add_b[Msb]) && (res[Msb] != a[Msb]);
            end
            OpSub: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];  // borrow
                res_v = (a[Msb] != b[Msb]) && (res[Msb] != a[Msb]);
            end
            OpAnd: res = a & b;
            OpOr:  res = a | b;
            OpXor: res = a ^ b;
            OpSll, OpSrl, OpSra: res = a;  // zero-amount shift passes a through
            default: res_err = 1'b1;
        endcase
    end

    // One shifter step on the working register.
    always_comb begin
        sh_next = result_q;
        sh_out  = 1'b0;
        case (shift_q)
            ShSll: begin
                sh_next = {result_q[WIDTH-2:0], 1'b0};
                sh_out  = result_q[Msb];
            end
            ShSrl: begin
                sh_next = {1'b0, result_q[WIDTH-1:1]};
                sh_out  = result_q[0];
            end
            ShSra: begin
                // MSB is never changed by SRA, so it still holds the original a[Msb].
                sh_next = {result_q[Msb], result_q[WIDTH-1:1]};
                sh_out  = result_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = err_q;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if ((op == OpSll || op == OpSrl || op == OpSra) && (amt != '0)) begin
                        state_d  = StShift;
                        cnt_d    = amt;
                        result_d = a;
                        z_d      = 1'b0;
                        n_d      = 1'b0;
                        c_d      = 1'b0;
                        v_d      = 1'b0;
                        err_d    = 1'b0;
                        case (op)
                            OpSll:   shift_d = ShSll;
                            OpSrl:   shift_d = ShSrl;
                            default: shift_d = ShSra;
                        endcase
                    end else begin
                        state_d  = StDone;
                        result_d = res;
                        z_d      = (res == '0);
                        n_d      = res[Msb];
                        c_d      = res_c;
                        v_d      = res_v;
                        err_d    = res_err;
                    end
                end else if (state_q == StDone && out_ready) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                result_d = sh_next;
                c_d      = sh_out;
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = StDone;
                    z_d     = (sh_next == '0);
                    n_d     = sh_next[Msb];
                    v_d     = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= ShSll;
            cnt_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        result    = result_q;
        flag_z    = z_q;
        flag_n    = n_q;
        flag_c    = c_q;
        flag_v    = v_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=16, IMM_W=8).
module tb_alu_seq_core;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned IMM_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IMM_W-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z, flag_n, flag_c, flag_v, err, busy;

    alu_seq_core #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  imm;
        logic [15:0] res;
        logic        z, n, c, v, e;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t stream[4];
    vec_t sb[$];
    vec_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int id, logic [3:0] o, logic [15:0] va, logic [15:0] vb,
                                logic [7:0] vi, logic [15:0] r, logic z, logic n, logic c,
                                logic v, logic e, int lat);
        vec_t t;
        t.id = id; t.op = o; t.a = va; t.b = vb; t.imm = vi; t.res = r;
        t.z = z; t.n = n; t.c = c; t.v = v; t.e = e; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        op = t.op; a = t.a; b = t.b; imm = t.imm;
    endtask

    // Pops the oldest expectation and compares it with the presented output.
    task automatic pop_check();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", result);
        end else begin
            e = sb.pop_front();
            chk($sformatf("out_%0d {res,z,n,c,v,err}", e.id),
                {11'd0, result, flag_z, flag_n, flag_c, flag_v, err},
                {11'd0, e.res, e.z, e.n, e.c, e.v, e.e});
        end
    endtask

    task automatic run_vec(input vec_t t);
        int  n;
        int  lat;
        bit  acc;
        cur = t;
        apply(t);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(t);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk($sformatf("accept_timeout_%0d", t.id), 32'd0, 32'd1);
            return;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && lat == 2) chk($sformatf("in_ready_busy_%0d", t.id), in_ready, 0);
        end while (!out_valid && lat < 40);
        chk($sformatf("latency_%0d", t.id), lat, t.lat);
        if (out_valid) pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx;
        int  c0;
        int  last_hs;
        int  n;
        bit  acc;
        bit  saw_valid;

        // Vector table: op, a, b, imm -> result, Z N C V err, latency.
        vecs.push_back(mk(0,  4'd1, 16'h0003, 16'h0005, 8'h00, 16'hFFFE, 0,1,1,0,0, 1));
        vecs.push_back(mk(1,  4'd0, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 0,1,0,1,0, 1));
        vecs.push_back(mk(2,  4'd2, 16'h0010, 16'h0000, 8'hFE, 16'h000E, 0,0,1,0,0, 1));
        vecs.push_back(mk(3,  4'd9, 16'h0010, 16'h1234, 8'hFE, 16'h000E, 0,0,1,0,0, 1));
        vecs.push_back(mk(4,  4'd8, 16'h8001, 16'h0004, 8'h00, 16'hF800, 0,1,0,0,0, 5));
        vecs.push_back(mk(5,  4'd6, 16'h8001, 16'h0001, 8'h00, 16'h0002, 0,0,1,0,0, 2));
        vecs.push_back(mk(6,  4'd3, 16'hF0F0, 16'hFF00, 8'h00, 16'hF000, 0,1,0,0,0, 1));
        vecs.push_back(mk(7,  4'd4, 16'h0F00, 16'h00F0, 8'h00, 16'h0FF0, 0,0,0,0,0, 1));
        vecs.push_back(mk(8,  4'd5, 16'hAAAA, 16'hAAAA, 8'h00, 16'h0000, 1,0,0,0,0, 1));
        vecs.push_back(mk(9,  4'd7, 16'hC000, 16'h000F, 8'h00, 16'h0001, 0,0,1,0,0, 16));
        vecs.push_back(mk(10, 4'd6, 16'h1234, 16'h0010, 8'h00, 16'h1234, 0,0,0,0,0, 1));
        vecs.push_back(mk(11, 4'd1, 16'h0005, 16'h0005, 8'h00, 16'h0000, 1,0,0,0,0, 1));
        vecs.push_back(mk(12, 4'd1, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 0,0,0,1,0, 1));
        vecs.push_back(mk(13, 4'd0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 1,0,1,0,0, 1));
        vecs.push_back(mk(14, 4'hF, 16'h1234, 16'h5678, 8'h12, 16'h0000, 1,0,0,0,1, 1));
        vecs.push_back(mk(15, 4'd0, 16'h0001, 16'h0001, 8'h00, 16'h0002, 0,0,0,0,0, 1));
        vecs.push_back(mk(16, 4'd2, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 0,1,0,1,0, 1));
        vecs.push_back(mk(17, 4'd7, 16'h0003, 16'h0001, 8'h00, 16'h0001, 0,0,1,0,0, 2));
        vecs.push_back(mk(18, 4'd8, 16'h8000, 16'h000F, 8'h00, 16'hFFFF, 0,1,0,0,0, 16));
        vecs.push_back(mk(19, 4'd9, 16'h1000, 16'h0000, 8'h80, 16'h0F80, 0,0,1,0,0, 1));
        vecs.push_back(mk(20, 4'hA, 16'h0001, 16'h0001, 8'h00, 16'h0000, 1,0,0,0,1, 1));

        stream[0] = mk(31, 4'd0, 16'h0001, 16'h0002, 8'h00, 16'h0003, 0,0,0,0,0, 1);
        stream[1] = mk(32, 4'd0, 16'h0010, 16'h0020, 8'h00, 16'h0030, 0,0,0,0,0, 1);
        stream[2] = mk(33, 4'd0, 16'hFFFF, 16'hFFFF, 8'h00, 16'hFFFE, 0,1,1,0,0, 1);
        stream[3] = mk(34, 4'd0, 16'h8000, 16'h8000, 8'h00, 16'h0000, 1,0,1,1,0, 1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; imm = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags_err", {flag_z, flag_n, flag_c, flag_v, err}, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stall in DONE for 3 cycles, then stream 4 back-to-back ADDs.
        out_ready = 1'b0;
        cur = mk(30, 4'd0, 16'h0100, 16'h0023, 8'h00, 16'h0123, 0,0,0,0,0, 1);
        apply(cur);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(cur);
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_accept", acc, 1);
        cur = stream[0];
        apply(cur);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_hold_%0d", k),
                {out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v, err},
                {1'b1, 1'b0, 16'h0123, 5'b00000});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idx = 0; c0 = -100; last_hs = -1; n = 0;
        while ((idx < 4 || sb.size() != 0) && n < 30) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                pop_check();
                last_hs = cyc + 1;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                sb.push_back(cur);
                if (idx == 0) c0 = cyc + 1;
                idx++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx < 4) begin
                    cur = stream[idx];
                    apply(cur);
                end else begin
                    in_valid = 1'b0;
                end
            end
            n++;
        end
        chk("stream_accepted", idx, 4);
        chk("stream_cycles", last_hs - c0, 4);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset while shifting drops the transaction.
        cur = mk(40, 4'd6, 16'h0001, 16'h000A, 8'h00, 16'h0400, 0,0,0,0,0, 11);
        apply(cur);
        @(negedge clk);
        chk("rst_seq_ready", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_seq_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_shift", {out_valid, busy, result}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready, 1);
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("rst_no_out_valid", saw_valid, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
